mux_n_1_rr: RTL

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input channel and on the output. It selects one input per cycle either from an explicit select input or by round-robin over the requesting channels, and holds the chosen word in a single output register. It is the streaming successor to the combinational 4:1 multiplexers and is used wherever several producers share one consumer.

---
 rtl/mux_pkg.sv | 26 ++
 rtl/rr_grant.sv | 31 +++
 rtl/mux_n_1_rr.sv | 83 ++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the round-robin stream multiplexer.
//   mux_mode_e    - grant source: explicit select or round-robin
//   MUX_MAX_N     - widest one-hot vector the index helper accepts
//   oh_to_idx()   - one-hot to binary index (0 when the vector is empty)
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MUX_MAX_N = 256;
    localparam int MUX_IDX_W = $clog2(MUX_MAX_N);

    // Callers zero-extend their grant to MUX_MAX_N and truncate the result
    // back to their own index width.
    function automatic logic [MUX_IDX_W-1:0] oh_to_idx(input logic [MUX_MAX_N-1:0] oh);
        logic [MUX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MUX_MAX_N; i++) begin
            if (oh[i]) idx = MUX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational rotate-priority arbiter.
//   req - per-channel request
//   ptr - last granted channel; search starts at ptr+1 (mod N)
//   gnt - one-hot grant, all zero when nothing requests
module rr_grant #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // Offset N wraps back to ptr itself, so the last winner is tried last.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_rr.sv
// mux_n_1_rr: N-input, W-bit registered multiplexer with valid/ready on each
// input and on the output. Grant comes from `sel` (MODE_SEL) or round-robin
// over valid channels (MODE_RR); the winner is captured in a one-entry
// output register.
//   in_data/in_valid/in_ready - N producer channels, channel i at [i*W +: W]
//   mode, sel                 - grant source and explicit channel index
//   out_data/out_chan/out_valid/out_ready - registered consumer side
module mux_n_1_rr
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     gnt_rr;
    logic [N-1:0]     gnt_sel;
    logic [N-1:0]     gnt;
    logic             can_accept;
    logic             in_xfer;
    logic [W-1:0]     win_data;
    logic [SEL_W-1:0] win_idx;

    rr_grant #(.N(N)) u_rr_grant (
        .req (in_valid),
        .ptr (ptr),
        .gnt (gnt_rr)
    );

    // Compare against each legal index so an out-of-range sel grants nothing.
    always_comb begin
        gnt_sel = '0;
        for (int i = 0; i < N; i++) begin
            gnt_sel[i] = (sel == SEL_W'(i)) && in_valid[i];
        end
    end

    assign gnt        = (mux_mode_e'(mode) == MODE_RR) ? gnt_rr : gnt_sel;
    assign can_accept = !out_valid || out_ready;
    assign in_ready   = gnt & {N{can_accept}};
    // in_ready is only ever set on a valid channel, so any bit is a transfer.
    assign in_xfer    = |in_ready;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) win_data = in_data[i*W +: W];
        end
    end

    assign win_idx = SEL_W'(oh_to_idx(MUX_MAX_N'(gnt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (in_xfer) begin
            // Also covers the same-cycle drain + reload case.
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_chan  <= win_idx;
            ptr       <= win_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
